// File: rtl/scaled_image_addr_gen.sv
// Registered, multiplier-free raster-to-image-address generator with 2^SCALE upscale.
// Optional horizontal mirror (mirror_h port) when IMG_ADDR_MIRROR_EN is defined.
module scaled_image_addr_gen #(
    parameter int IMG_W     = 240,
    parameter int IMG_H     = 240,
    parameter int SCALE     = 1,
    parameter int ADDR_W    = 16,
    parameter int LINE_LAST = 799
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic [9:0]        x_pos,
    input  logic [9:0]        y_pos,
`ifdef IMG_ADDR_MIRROR_EN
    input  logic              mirror_h,
`endif
    output logic [ADDR_W-1:0] addr,
    output logic              in_window,
    output logic              last_px
);

    localparam logic [10:0]       W_OUT    = 11'(IMG_W << SCALE);
    localparam logic [10:0]       H_OUT    = 11'(IMG_H << SCALE);
    localparam logic [9:0]        LL       = 10'(LINE_LAST);
    localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'((IMG_H - 1) * IMG_W);

    logic [9:0]        x0, y0;
    logic [ADDR_W-1:0] row_base, col;
    logic [ADDR_W-1:0] cur_row, cur_col, pix_col;
    logic              fstart, h_start, h_in, v_in, in_win, line_end;
    logic              h_wrap, v_wrap;

    always_comb begin
        fstart   = (hcount == 10'd0) && (vcount == 10'd0);
        h_start  = (hcount == x0);
        h_in     = ({1'b0, hcount} >= {1'b0, x0}) &&
                   ({1'b0, hcount} < ({1'b0, x0} + W_OUT));
        v_in     = ({1'b0, vcount} >= {1'b0, y0}) &&
                   ({1'b0, vcount} < ({1'b0, y0} + H_OUT));
        in_win   = h_in && v_in;
        line_end = (hcount == LL) && v_in;
        // Frame start restarts the row walk for pixel (0,0) itself
        cur_row  = fstart ? '0 : row_base;
        cur_col  = h_start ? '0 : col;
    end

    generate
        if (SCALE == 0) begin : g_nosub
            assign h_wrap = 1'b1;
            assign v_wrap = 1'b1;
        end else begin : g_sub
            logic [SCALE-1:0] hsub, vsub, cur_hsub, cur_vsub;

            always_comb begin
                cur_hsub = h_start ? '0 : hsub;
                cur_vsub = fstart ? '0 : vsub;
            end

            assign h_wrap = &cur_hsub;
            assign v_wrap = &cur_vsub;

            always_ff @(posedge clk) begin
                if (reset) begin
                    hsub <= '0;
                    vsub <= '0;
                end else begin
                    if (in_win)
                        hsub <= cur_hsub + 1'b1;
                    if (line_end)
                        vsub <= cur_vsub + 1'b1;
                    else if (fstart)
                        vsub <= '0;
                end
            end
        end
    endgenerate

`ifdef IMG_ADDR_MIRROR_EN
    logic mirror;

    always_ff @(posedge clk) begin
        if (reset)
            mirror <= 1'b0;
        else if (fstart)
            mirror <= mirror_h;
    end

    assign pix_col = mirror ? (LAST_COL - cur_col) : cur_col;
`else
    assign pix_col = cur_col;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            x0        <= '0;
            y0        <= '0;
            row_base  <= '0;
            col       <= '0;
            addr      <= '0;
            in_window <= 1'b0;
            last_px   <= 1'b0;
        end else begin
            if (fstart) begin
                x0 <= x_pos;
                y0 <= y_pos;
            end
            if (line_end && v_wrap)
                row_base <= cur_row + IMG_W_A;
            else if (fstart)
                row_base <= '0;
            if (in_win)
                col <= h_wrap ? cur_col + 1'b1 : cur_col;
            addr      <= in_win ? cur_row + pix_col : '0;
            in_window <= in_win;
            // Last replica of the last window pixel, mirrored or not
            last_px   <= in_win && h_wrap && v_wrap &&
                         (cur_col == LAST_COL) && (cur_row == LAST_ROW);
        end
    end

endmodule

// File: tb/tb_scaled_image_addr_gen.sv
// Directed bench for scaled_image_addr_gen: 240x240 x2 instance plus a 4x3 1:1 instance.
// Mirror steps compile only when IMG_ADDR_MIRROR_EN is defined.
module tb_scaled_image_addr_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hcount, vcount, x_pos, y_pos, x5, y5;
    logic [15:0] addr, addr5;
    logic        in_window, last_px, in5, lp5;
`ifdef IMG_ADDR_MIRROR_EN
    logic        mirror_h;
`endif
    int n_cmp = 0;
    int n_err = 0;
    int lp_cnt = 0;

    always #5 clk = ~clk;

    scaled_image_addr_gen #(
        .IMG_W(240), .IMG_H(240), .SCALE(1), .ADDR_W(16), .LINE_LAST(799)
    ) dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .x_pos(x_pos), .y_pos(y_pos),
`ifdef IMG_ADDR_MIRROR_EN
        .mirror_h(mirror_h),
`endif
        .addr(addr), .in_window(in_window), .last_px(last_px)
    );

    scaled_image_addr_gen #(
        .IMG_W(4), .IMG_H(3), .SCALE(0), .ADDR_W(16), .LINE_LAST(799)
    ) dut5 (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .x_pos(x5), .y_pos(y5),
`ifdef IMG_ADDR_MIRROR_EN
        .mirror_h(1'b0),
`endif
        .addr(addr5), .in_window(in5), .last_px(lp5)
    );

    task automatic drive(input int h, input int v);
        hcount = 10'(h);
        vcount = 10'(v);
        @(posedge clk);
        #1;
        if (last_px === 1'b1)
            lp_cnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        x_pos = 10'd0;
        y_pos = 10'd0;
        x5    = 10'd630;
        y5    = 10'd0;
`ifdef IMG_ADDR_MIRROR_EN
        mirror_h = 1'b0;
`endif
        hcount = '0;
        vcount = '0;

        for (int i = 0; i < 3; i++) begin
            drive(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            chk("rst_addr", 32'(addr), 0);
            chk("rst_inwin", 32'(in_window), 0);
            chk("rst_last", 32'(last_px), 0);
        end
        reset = 1'b0;

        lp_cnt = 0;
        drive(0, 0);
        chk("s1_00_addr", 32'(addr), 0);
        chk("s1_00_in", 32'(in_window), 1);
        drive(1, 0);
        chk("s1_10_addr", 32'(addr), 0);
        drive(2, 0);
        chk("s1_20_addr", 32'(addr), 1);
        for (int h = 3; h <= 479; h++)
            drive(h, 0);
        drive(480, 0);
        chk("s1_480_out", 32'(in_window), 0);
        drive(799, 0);
        for (int h = 0; h <= 479; h++)
            drive(h, 1);
        chk("s1_479_1", 32'(addr), 239);
        drive(799, 1);
        drive(0, 2);
        chk("s1_0_2", 32'(addr), 240);
        for (int v = 2; v <= 478; v++)
            drive(799, v);
        for (int h = 0; h <= 479; h++) begin
            drive(h, 479);
            if (h == 478)
                chk("s1_lp_early", 32'(last_px), 0);
        end
        chk("s1_479_479", 32'(addr), 57599);
        chk("s1_lp_hi", 32'(last_px), 1);
        drive(799, 479);
        drive(0, 480);
        chk("s1_v480_out", 32'(in_window), 0);
        chk("s1_lp_count", 32'(lp_cnt), 1);

        x_pos = 10'd100;
        y_pos = 10'd50;
        drive(0, 0);
        chk("s2_00_oldorg", 32'(in_window), 1);
        drive(100, 49);
        chk("s2_100_49", 32'(in_window), 0);
        drive(99, 50);
        chk("s2_99_50", 32'(in_window), 0);
        drive(100, 50);
        chk("s2_100_in", 32'(in_window), 1);
        chk("s2_100_addr", 32'(addr), 0);
        for (int h = 101; h <= 579; h++)
            drive(h, 50);
        chk("s2_579_addr", 32'(addr), 239);
        drive(580, 50);
        chk("s2_580_in", 32'(in_window), 0);
        chk("s2_580_addr", 32'(addr), 0);

        x_pos = 10'd0;
        y_pos = 10'd0;
        drive(0, 0);
        chk("s3_00_oldorg", 32'(in_window), 0);
        x_pos = 10'd200;
        drive(0, 100);
        chk("s3_0_100", 32'(in_window), 1);
        drive(150, 100);
        chk("s3_150_100", 32'(in_window), 1);
        drive(0, 0);
        chk("s3_00_frame", 32'(in_window), 1);
        drive(199, 0);
        chk("s3_199_0", 32'(in_window), 0);
        drive(200, 0);
        chk("s3_200_in", 32'(in_window), 1);
        chk("s3_200_addr", 32'(addr), 0);
        drive(201, 0);
        chk("s3_201_addr", 32'(addr), 0);
        drive(202, 0);
        chk("s3_202_addr", 32'(addr), 1);

        drive(0, 0);
        chk("s4_00_in", 32'(in5), 0);
        drive(629, 0);
        chk("s4_629_in", 32'(in5), 0);
        for (int h = 630; h <= 633; h++) begin
            drive(h, 0);
            chk("s4_r0_in", 32'(in5), 1);
            chk("s4_r0_addr", 32'(addr5), h - 630);
        end
        drive(634, 0);
        chk("s4_634_in", 32'(in5), 0);
        drive(799, 0);
        drive(0, 1);
        chk("s4_nowrap", 32'(in5), 0);
        drive(799, 1);
        for (int h = 630; h <= 633; h++) begin
            drive(h, 2);
            chk("s4_r2_addr", 32'(addr5), 8 + h - 630);
        end
        chk("s4_lp", 32'(lp5), 1);
        drive(799, 2);
        drive(630, 3);
        chk("s4_v3_in", 32'(in5), 0);

`ifdef IMG_ADDR_MIRROR_EN
        x_pos = 10'd0;
        mirror_h = 1'b1;
        drive(0, 0);
        drive(0, 0);
        chk("s5_00_mir", 32'(addr), 239);
        for (int h = 1; h <= 478; h++)
            drive(h, 0);
        chk("s5_478_mir", 32'(addr), 0);
        drive(799, 0);
        drive(799, 1);
        drive(0, 2);
        chk("s5_0_2_mir", 32'(addr), 479);
        mirror_h = 1'b0;
`endif

        x_pos = 10'd0;
        drive(250, 300);
        chk("s6_pre_in", 32'(in_window), 1);
        reset = 1'b1;
        drive(260, 300);
        chk("s6_rst_addr", 32'(addr), 0);
        chk("s6_rst_in", 32'(in_window), 0);
        chk("s6_rst_lp", 32'(last_px), 0);
        reset = 1'b0;
        drive(0, 0);
        chk("s6_00_in", 32'(in_window), 1);
        chk("s6_00_addr", 32'(addr), 0);
        drive(1, 0);
        drive(2, 0);
        chk("s6_20_addr", 32'(addr), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
